// File: rtl/bidirect_shift_reg.sv
// bidirect_shift_reg: parallel-load bidirectional shift register with hold.
// Ports: clk, rst (async active-low), sel (00 hold / 01 shift right /
//        10 shift left / 11 load), left_in (enters MSB on shift right),
//        right_in (enters LSB on shift left), parallel_in, q (register state).
module bidirect_shift_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       sel,
    input  logic             left_in,
    input  logic             right_in,
    input  logic [WIDTH-1:0] parallel_in,
    output logic [WIDTH-1:0] q
);

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_SHR   = 2'b01,
        MODE_SHL   = 2'b10,
        MODE_LOAD  = 2'b11
    } mode_e;

    mode_e            mode;
    logic [WIDTH-1:0] q_next;

    assign mode = mode_e'(sel);

    // No wrap-around: the bit shifted out is dropped; rotation is
    // built outside by feeding q back into the serial input.
    always_comb begin
        q_next = q;
        unique case (mode)
            MODE_HOLD: q_next = q;
            MODE_SHR:  q_next = {left_in, q[WIDTH-1:1]};
            MODE_SHL:  q_next = {q[WIDTH-2:0], right_in};
            MODE_LOAD: q_next = parallel_in;
            default:   q_next = q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else begin
            q <= q_next;
        end
    end

endmodule

// File: tb/tb_bidirect_shift_reg.sv
// tb_bidirect_shift_reg: directed + randomized check of bidirect_shift_reg
// against an arithmetic reference model of the register contents.
module tb_bidirect_shift_reg;

    localparam int W    = 4;
    localparam int MASK = (1 << W) - 1;

    logic         clk;
    logic         rst;
    logic [1:0]   sel;
    logic         left_in;
    logic         right_in;
    logic [W-1:0] parallel_in;
    logic [W-1:0] q;

    int n_vec;
    int n_err;
    int model;

    bidirect_shift_reg #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .sel         (sel),
        .left_in     (left_in),
        .right_in    (right_in),
        .parallel_in (parallel_in),
        .q           (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One rising edge; model is advanced from the inputs sampled there.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            case (sel)
                2'b00: model = model;
                2'b01: model = (model >> 1) | (int'(left_in) << (W - 1));
                2'b10: model = ((model << 1) | int'(right_in)) & MASK;
                default: model = int'(parallel_in);
            endcase
        end else begin
            model = 0;
        end
        #1;
    endtask

    task automatic drive(input logic [1:0] s, input logic li,
                         input logic ri, input logic [W-1:0] p);
        sel = s;
        left_in = li;
        right_in = ri;
        parallel_in = p;
    endtask

    // Pulse reset low between edges; q must clear without a clock.
    task automatic async_pulse(input string tag);
        #2;
        rst = 1'b0;
        model = 0;
        #1;
        check_eq(tag, int'(q), 0);
        rst = 1'b1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        model = 0;
        rst = 1'b0;
        drive(2'b11, 1'b1, 1'b1, 4'b1111);
        #1;
        check_eq("reset_async", int'(q), 0);
        step();
        check_eq("reset_held1", int'(q), 0);
        step();
        check_eq("reset_held2", int'(q), 0);
        rst = 1'b1;

        drive(2'b11, 1'b1, 1'b1, 4'b1010);
        step();
        check_eq("load_1010", int'(q), 'b1010);
        drive(2'b00, 1'b1, 1'b1, 4'b0101);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("hold_1010", int'(q), 'b1010);
        end

        drive(2'b01, 1'b0, 1'b1, 4'b1111);
        step();
        check_eq("shr_li0", int'(q), 'b0101);
        drive(2'b01, 1'b1, 1'b0, 4'b0000);
        step();
        check_eq("shr_li1", int'(q), 'b1010);
        drive(2'b01, 1'b0, 1'b1, 4'b1111);
        step();
        check_eq("shr_again", int'(q), 'b0101);

        drive(2'b10, 1'b1, 1'b0, 4'b1111);
        step();
        check_eq("shl_ri0", int'(q), 'b1010);

        drive(2'b11, 1'b0, 1'b0, 4'b0000);
        step();
        check_eq("load_0000", int'(q), 0);
        drive(2'b10, 1'b0, 1'b1, 4'b1010);
        step();
        check_eq("shl_fill1", int'(q), 'b0001);
        step();
        check_eq("shl_fill2", int'(q), 'b0011);
        step();
        check_eq("shl_fill3", int'(q), 'b0111);
        step();
        check_eq("shl_fill4", int'(q), 'b1111);
        step();
        check_eq("shl_drop_msb", int'(q), 'b1111);

        drive(2'b11, 1'b1, 1'b1, 4'b1100);
        step();
        check_eq("reload_1100", int'(q), 'b1100);
        drive(2'b00, 1'b1, 1'b0, 4'b0011);
        step();
        step();
        check_eq("hold_1100", int'(q), 'b1100);

        drive(2'b01, 1'b1, 1'b0, 4'b0000);
        step();
        check_eq("shr_pre_rst", int'(q), 'b1110);
        async_pulse("rst_mid_op");
        drive(2'b11, 1'b0, 1'b0, 4'b0110);
        step();
        check_eq("load_after_rst", int'(q), 'b0110);

        for (int i = 0; i < 400; i++) begin
            drive(2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                  W'($urandom));
            step();
            check_eq("random", int'(q), model);
            if ($urandom_range(0, 24) == 0) begin
                async_pulse("random_rst");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
